// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - bfloat16 float-op sequencer driving a shared fixed-latency core
// Accepts one op at a time, sequences divide as reciprocal then multiply, holds result for writeback.
module fpu_sequencer #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int RCP_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_dest,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        core_go,
    output logic [1:0]  core_sel,
    output logic [15:0] core_a,
    output logic [15:0] core_b,
    input  logic [15:0] core_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_dest,
    output logic [15:0] wb_data,
    output logic        busy,
    output logic [3:0]  busy_dest,
    output logic        err,
    output logic        div0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DIV2,
        S_WB,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_RCP = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    localparam int CW = 8;
    // The go cycle is the first core cycle, so the wait count is one short of the latency.
    localparam logic [CW-1:0] ADD_M1  = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_M1  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] RCP_M1  = CW'(RCP_LAT - 1);
    localparam logic [CW-1:0] RCP_FUL = CW'(RCP_LAT);

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [3:0]     dest_q, dest_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phase2_q, phase2_d;
    logic [15:0]    res_q, res_d;

    logic           is_div;
    logic           is_recip;
    logic           zero_div;
    logic           div_first;
    logic [CW-1:0]  lat_m1;
    logic [CW-1:0]  capture_at;

    always_comb begin
        is_div     = (op_q == OP_DIV);
        is_recip   = (op_q == OP_RCP) || is_div;
        zero_div   = is_recip && (b_q[14:7] == 8'h00);
        div_first  = is_div && !phase2_q;
        lat_m1     = (op_q == OP_MUL) ? MUL_M1 : (is_recip ? RCP_M1 : ADD_M1);
        // First divide phase waits one extra turnaround cycle after the reciprocal lands.
        capture_at = div_first ? CW'(2) : CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dest_d    = dest_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        phase2_d  = phase2_q;
        res_d     = res_q;
        req_ready = 1'b0;
        core_go   = 1'b0;
        core_sel  = 2'd0;
        core_a    = a_q;
        core_b    = b_q;
        wb_valid  = 1'b0;
        err       = 1'b0;
        div0      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                phase2_d  = 1'b0;
                if (req_valid) begin
                    op_d    = req_op;
                    dest_d  = req_dest;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = (req_op > OP_DIV) ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (zero_div) begin
                    div0    = 1'b1;
                    res_d   = {(is_div ? (a_q[15] ^ b_q[15]) : b_q[15]), 8'hFF, 7'h00};
                    state_d = S_WB;
                end else begin
                    core_go  = 1'b1;
                    core_sel = is_recip ? 2'd3 : op_q[1:0];
                    cnt_d    = is_div ? RCP_FUL : lat_m1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == capture_at) begin
                    res_d = core_result;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = div_first ? S_DIV2 : S_WB;
                end
            end
            S_DIV2: begin
                core_go  = 1'b1;
                core_sel = 2'd2;
                core_b   = res_q;
                cnt_d    = MUL_M1;
                phase2_d = 1'b1;
                state_d  = S_WAIT;
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            dest_q   <= 4'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            cnt_q    <= '0;
            phase2_q <= 1'b0;
            res_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            phase2_q <= phase2_d;
            res_q    <= res_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign busy_dest = dest_q;
    assign wb_dest   = dest_q;
    assign wb_data   = res_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - self-checking bench for fpu_sequencer
// Core model returns a hash of its operands exactly at the completion cycle and noise otherwise.
module tb_fpu_sequencer;

    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 3;
    localparam int RCP_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_dest;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        core_go;
    logic [1:0]  core_sel;
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic [15:0] core_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        busy;
    logic [3:0]  busy_dest;
    logic        err;
    logic        div0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -10;
    logic [15:0] done_val = 16'h0;

    fpu_sequencer #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .RCP_LAT(RCP_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_dest(req_dest),
        .req_a(req_a),
        .req_b(req_b),
        .core_go(core_go),
        .core_sel(core_sel),
        .core_a(core_a),
        .core_b(core_b),
        .core_result(core_result),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_dest(wb_dest),
        .wb_data(wb_data),
        .busy(busy),
        .busy_dest(busy_dest),
        .err(err),
        .div0(div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] core_fn(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
        if (sel == 2'd3) return {b[7:0], b[15:8]} ^ 16'h3C5A;
        return (a * 16'd3) + (b * 16'd5) + {11'd0, sel, 3'b101};
    endfunction

    function automatic int core_lat(input logic [1:0] sel);
        if (sel == 2'd2) return MUL_LAT;
        if (sel == 2'd3) return RCP_LAT;
        return ADD_LAT;
    endfunction

    always @(negedge clk) begin
        if (core_go) begin
            done_cyc = cyc + core_lat(core_sel) - 1;
            done_val = core_fn(core_sel, core_a, core_b);
        end
        core_result = (cyc == done_cyc) ? done_val : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [3:0] dest, input logic [15:0] a,
                          input logic [15:0] b, input int stall);
        bit illegal, zdiv, isdiv, done, in_wb, hs;
        int go1, go2, wbk;
        logic [15:0] rcp, exp_data;
        logic [1:0] sel1;
        illegal  = (op > 3'd4);
        isdiv    = (op == 3'd4);
        zdiv     = !illegal && (op >= 3'd3) && (b[14:7] == 8'h00);
        go1 = -1; go2 = -1; wbk = -1;
        rcp = 16'h0; exp_data = 16'h0; sel1 = 2'd0; done = 1'b0;
        if (illegal) begin
            wbk = -1;
        end else if (zdiv) begin
            wbk = 2;
            exp_data = {(isdiv ? (a[15] ^ b[15]) : b[15]), 8'hFF, 7'h00};
        end else if (isdiv) begin
            go1 = 1; go2 = RCP_LAT + 2; wbk = RCP_LAT + MUL_LAT + 2; sel1 = 2'd3;
            rcp = core_fn(2'd3, a, b);
            exp_data = core_fn(2'd2, a, rcp);
        end else begin
            sel1 = (op == 3'd3) ? 2'd3 : op[1:0];
            go1 = 1; wbk = core_lat(sel1) + 1;
            exp_data = core_fn(sel1, a, b);
        end
        chk("ready_before_accept", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_dest = dest; req_a = a; req_b = b; wb_ready = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if ((illegal && k == 2) || (wbk > 0 && k == wbk + stall + 1)) begin
                chk("end_req_ready", req_ready, 1);
                chk("end_busy", busy, 0);
                chk("end_wb_valid", wb_valid, 0);
                chk("end_core_go", core_go, 0);
                chk("end_err", err, 0);
                done = 1'b1;
            end else begin
                in_wb = (wbk > 0) && (k >= wbk);
                chk("busy", busy, 1);
                chk("req_ready", req_ready, 0);
                chk("busy_dest", busy_dest, dest);
                chk("core_go", core_go, (k == go1) || (k == go2));
                if (k == go1) begin
                    chk("go1_sel", core_sel, sel1);
                    chk("go1_b", core_b, b);
                    if (sel1 != 2'd3) chk("go1_a", core_a, a);
                end
                if (k == go2) begin
                    chk("go2_sel", core_sel, 2'd2);
                    chk("go2_a", core_a, a);
                    chk("go2_b_recip", core_b, rcp);
                end
                chk("err", err, illegal && k == 1);
                chk("div0", div0, zdiv && k == 1);
                chk("wb_valid", wb_valid, in_wb);
                if (in_wb) begin
                    chk("wb_dest", wb_dest, dest);
                    chk("wb_data", wb_data, exp_data);
                end
                hs = (wbk > 0) && (k == wbk + stall);
                if (hs || (illegal && k == 1)) begin
                    req_valid = 1'b0;
                    wb_ready  = hs;
                end else begin
                    req_valid = 1'($urandom);
                    req_op    = 3'($urandom);
                    req_dest  = 4'($urandom);
                    req_a     = 16'($urandom);
                    req_b     = 16'($urandom);
                    wb_ready  = in_wb ? 1'b0 : 1'($urandom);
                end
            end
        end
        req_valid = 1'b0;
        wb_ready  = 1'b0;
        chk("op_complete", done, 1);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [15:0] r_b;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_dest = 4'd0;
        req_a = 16'h0; req_b = 16'h0; wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_core_go", core_go, 0);
        chk("rst_wb_data", wb_data, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 4'd3, 16'h3F80, 16'h4000, 0);
        run_op(3'd4, 4'd5, 16'h4040, 16'h4000, 0);
        run_op(3'd3, 4'd1, 16'h1234, 16'h8000, 0);
        run_op(3'd2, 4'd7, 16'h4110, 16'hC020, 3);
        run_op(3'd6, 4'd2, 16'h1111, 16'h2222, 0);
        run_op(3'd4, 4'd6, 16'hC040, 16'h0055, 1);
        run_op(3'd1, 4'd8, 16'h4000, 16'h3F80, 2);

        chk("mid_div_ready", req_ready, 1);
        req_valid = 1'b1; req_op = 3'd4; req_dest = 4'd9; req_a = 16'h4080; req_b = 16'h4000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_div_go", core_go, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_core_go", core_go, 0);
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_err", err, 0);
        chk("mrst_div0", div0, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_busy_dest", busy_dest, 0);
        chk("mrst_wb_dest", wb_dest, 0);
        chk("mrst_wb_data", wb_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_wb_valid", wb_valid, 0);
            chk("post_rst_core_go", core_go, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_op(3'd0, 4'd4, 16'h3F80, 16'h3F80, 0);

        for (int i = 0; i < 60; i++) begin
            r_op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            r_b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_b[14:7] = 8'h00;
            run_op(r_op, 4'($urandom), 16'($urandom), r_b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
